multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port Op  in  6  opcode from instruction register, valid from DECODE onward.
REQ-004 SHALL have port Funct  in  6  R-type function field, valid from DECODE onward.
REQ-005 SHALL have port Zero  in  1  ALU zero flag, valid in EXEC.
REQ-006 SHALL have port MemReady  in  1  memory access complete this cycle.
REQ-007 SHALL have ports IRWrite, PCWrite, MemRead, MemWrite, RegWE  out  1 each  datapath strobes.
REQ-008 SHALL have port PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target.
REQ-009 SHALL have ports WadrSel, WdataSel  out  2 each  WadrSel: 00 rt, 01 rd, 10 r31; WdataSel: 00 ALU, 01 mem, 10 PC+4.
REQ-010 SHALL have port ALUSrcB  out  2  00 rt data, 01 constant 4, 10 extended imm, 11 extended imm<<2.
REQ-011 SHALL have port ALUOp  out  3  000 add, 001 sub, 010 Funct-decoded, 011 and, 100 or, 101 xor, 110 slt.
REQ-012 SHALL have port ExtUnsigned  out  1  zero-extend imm (andi 001100, ori 001101, xori 001110), else sign-extend.
REQ-013 SHALL have ports State  out  3, InsDone  out  1, InsCount  out  16  state, retire pulse, retired count.

Function
REQ-014 SHALL encode states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH next cycle with all strobes 0.
REQ-015 FETCH: MemRead=1, ALUSrcB=01, ALUOp=000; stay while MemReady=0; when MemReady=1, IRWrite=1, PCWrite=1, PCSrc=00, next DECODE.
REQ-016 DECODE: ALUSrcB=11, ALUOp=000 (branch target precompute); j(000010): PCWrite=1, PCSrc=10, InsDone=1, next FETCH; jal(000011): next WB; R(000000), lw(100011), sw(101011), beq(000100), bne(000101), addi(001000), slti(001010), andi/ori/xori: next EXEC; any other Op: InsDone=1, next FETCH (nop, no writes).
REQ-017 EXEC ALU ops: R: ALUSrcB=00, ALUOp=010; addi: 10/000; slti: 10/110; andi/ori/xori: 10/011,100,101; next WB.
REQ-018 EXEC lw/sw: ALUSrcB=10, ALUOp=000, next MEM.
REQ-019 EXEC beq/bne: ALUSrcB=00, ALUOp=001, PCSrc=01; PCWrite=Zero (beq) or !Zero (bne); InsDone=1; next FETCH.
REQ-020 MEM: lw drives MemRead=1, sw drives MemWrite=1, held while MemReady=0; on MemReady=1 lw next WB, sw InsDone=1 next FETCH.
REQ-021 WB: RegWE=1 exactly one cycle, InsDone=1, next FETCH; WadrSel=01/WdataSel=00 for R, 00/01 for lw, 10/10 for jal, 00/00 for I-type ALU.
REQ-022 RegWE SHALL never assert for j, beq, bne, sw, or unknown Op.
REQ-023 ExtUnsigned SHALL be valid in DECODE and EXEC; 0 in all other states.
REQ-024 Strobes SHALL be combinational from State, Op, Funct, Zero, MemReady; any strobe not listed for a state SHALL be 0.
REQ-025 InsCount SHALL increment by 1 on each cycle with InsDone=1, wrapping 0xFFFF->0x0000.
REQ-026 Latency: j 2 cycles, beq/bne/unknown-free path 3, R/I-type 4, sw 4, lw 5, jal 3, each plus memory wait cycles.

Reset
REQ-027 On rising CLK with RST=1: State=FETCH, InsCount=0; RST SHALL override any pending transition, including MEM mid-access and FETCH wait.
REQ-028 While RST=1, all strobes and InsDone SHALL be 0 regardless of state.

Verification
REQ-029 Reset then R-type add (Op=0, Funct=100000), MemReady=1 -> states 0,1,2,4,0; RegWE=1 only in WB with WadrSel=01; InsCount=1.
REQ-030 lw with MemReady low 3 cycles in MEM -> MemRead held 3 cycles, WB on 5th access cycle, WdataSel=01, RegWE pulse once.
REQ-031 beq Zero=1 then beq Zero=0 -> PCWrite=1/PCSrc=01 first, PCWrite=0 second; RegWE=0 both; InsCount +2.
REQ-032 jal -> DECODE then WB with WadrSel=10, WdataSel=10; j -> PCWrite, PCSrc=10 in DECODE, back to FETCH, no RegWE.
REQ-033 ori Op=001101 -> ExtUnsigned=1, ALUOp=100 in EXEC; Op=111111 -> nop, InsDone in DECODE, no writes.
REQ-034 RST asserted during sw MEM wait -> MemWrite=0 next cycle, State=0, InsCount=0; 65536 retired nops -> InsCount wraps to 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: datapath/controller bundle for the multi-cycle controller.
// The controller side is the master modport; the datapath side is the slave modport.
interface multi_cycle_ctrl_if;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        MemReady;
    logic        IRWrite;
    logic        PCWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWE;
    logic [1:0]  PCSrc;
    logic [1:0]  WadrSel;
    logic [1:0]  WdataSel;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic        ExtUnsigned;
    logic [2:0]  State;
    logic        InsDone;
    logic [15:0] InsCount;
    modport master (
        input  Op, Funct, Zero, MemReady,
        output IRWrite, PCWrite, MemRead, MemWrite, RegWE, PCSrc, WadrSel, WdataSel,
               ALUSrcB, ALUOp, ExtUnsigned, State, InsDone, InsCount
    );
    modport slave (
        output Op, Funct, Zero, MemReady,
        input  IRWrite, PCWrite, MemRead, MemWrite, RegWE, PCSrc, WadrSel, WdataSel,
               ALUSrcB, ALUOp, ExtUnsigned, State, InsDone, InsCount
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: five-state MIPS-style multi-cycle controller with combinational strobes.
module multi_cycle_ctrl (
    input logic CLK,
    input logic RST,
    multi_cycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    state_t state, next;
    logic [15:0] count;
    logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_slti, is_andi, is_ori, is_xori, is_j, is_jal;
    logic is_ext, is_ialu, is_mem, is_br, to_exec;
    assign is_r    = bus.Op == 6'b000000;
    assign is_j    = bus.Op == 6'b000010;
    assign is_jal  = bus.Op == 6'b000011;
    assign is_beq  = bus.Op == 6'b000100;
    assign is_bne  = bus.Op == 6'b000101;
    assign is_addi = bus.Op == 6'b001000;
    assign is_slti = bus.Op == 6'b001010;
    assign is_andi = bus.Op == 6'b001100;
    assign is_ori  = bus.Op == 6'b001101;
    assign is_xori = bus.Op == 6'b001110;
    assign is_lw   = bus.Op == 6'b100011;
    assign is_sw   = bus.Op == 6'b101011;
    assign is_ext  = is_andi | is_ori | is_xori;
    assign is_ialu = is_addi | is_slti | is_ext;
    assign is_mem  = is_lw | is_sw;
    assign is_br   = is_beq | is_bne;
    assign to_exec = is_r | is_mem | is_br | is_ialu;
    // Reset gates every strobe, so the datapath sees no writes while RST is held.
    always_comb begin
        next = FETCH;
        bus.IRWrite = 1'b0;
        bus.PCWrite = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWE = 1'b0;
        bus.PCSrc = 2'b00;
        bus.WadrSel = 2'b00;
        bus.WdataSel = 2'b00;
        bus.ALUSrcB = 2'b00;
        bus.ALUOp = 3'b000;
        bus.ExtUnsigned = 1'b0;
        bus.InsDone = 1'b0;
        if (!RST) begin
            case (state)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                    next = bus.MemReady ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ExtUnsigned = is_ext;
                    bus.PCWrite = is_j;
                    bus.PCSrc = is_j ? 2'b10 : 2'b00;
                    bus.InsDone = !is_jal && !to_exec;
                    next = is_jal ? WB : to_exec ? EXEC : FETCH;
                end
                EXEC: begin
                    bus.ExtUnsigned = is_ext;
                    bus.ALUSrcB = (is_ialu || is_mem) ? 2'b10 : 2'b00;
                    bus.ALUOp = is_r ? 3'b010 : is_br ? 3'b001 : is_slti ? 3'b110 :
                                is_andi ? 3'b011 : is_ori ? 3'b100 : is_xori ? 3'b101 : 3'b000;
                    bus.PCSrc = is_br ? 2'b01 : 2'b00;
                    bus.PCWrite = (is_beq && bus.Zero) || (is_bne && !bus.Zero);
                    bus.InsDone = is_br;
                    next = is_mem ? MEM : (is_r || is_ialu) ? WB : FETCH;
                end
                MEM: begin
                    bus.MemRead = is_lw;
                    bus.MemWrite = is_sw;
                    bus.InsDone = is_sw && bus.MemReady;
                    next = !is_mem ? FETCH : !bus.MemReady ? MEM : is_lw ? WB : FETCH;
                end
                WB: begin
                    bus.RegWE = is_r | is_lw | is_jal | is_ialu;
                    bus.InsDone = 1'b1;
                    bus.WadrSel = is_r ? 2'b01 : is_jal ? 2'b10 : 2'b00;
                    bus.WdataSel = is_lw ? 2'b01 : is_jal ? 2'b10 : 2'b00;
                end
                default: next = FETCH;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= next;
            if (bus.InsDone) count <= count + 16'd1;
        end
    end
    assign bus.State = state;
    assign bus.InsCount = count;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed scenario tasks with hand-computed strobe vectors.
// Vector layout: {IRWrite,PCWrite,MemRead,MemWrite,RegWE,InsDone, PCSrc, WadrSel, WdataSel, ALUSrcB, ALUOp, ExtUnsigned}.
module tb_multi_cycle_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [17:0] exp;
    logic [17:0] sig;
    multi_cycle_ctrl_if bus();
    multi_cycle_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    assign sig = {bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite, bus.RegWE, bus.InsDone,
                  bus.PCSrc, bus.WadrSel, bus.WdataSel, bus.ALUSrcB, bus.ALUOp, bus.ExtUnsigned};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op);
        bus.Op = op;
        bus.Funct = 6'b100000;
        bus.MemReady = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.Op = 6'b000000;
        bus.Funct = 6'b100000;
        bus.Zero = 1'b0;
        bus.MemReady = 1'b1;
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd0 || sig !== 18'd0) begin
            errors++;
            $display("FAIL reset state=%0d count=%0d sig=%b want 0/0/0", bus.State, bus.InsCount, sig);
        end
        RST = 1'b0;
    endtask

    task automatic test_r_type();
        #1;
        exp = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd0 || sig !== exp) begin errors++; $display("FAIL r_fetch state=%0d sig=%b want 0 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd1 || sig !== exp) begin errors++; $display("FAIL r_decode state=%0d sig=%b want 1 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0};
        checks++;
        if (bus.State !== 3'd2 || sig !== exp) begin errors++; $display("FAIL r_exec state=%0d sig=%b want 2 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000011, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd4 || sig !== exp) begin errors++; $display("FAIL r_wb state=%0d sig=%b want 4 %b", bus.State, sig, exp); end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd1) begin errors++; $display("FAIL r_done state=%0d count=%0d want 0/1", bus.State, bus.InsCount); end
    endtask

    task automatic test_lw_wait();
        bus.Op = 6'b100011;
        bus.MemReady = 1'b0;
        #1;
        exp = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd0 || sig !== exp) begin errors++; $display("FAIL lw_fetch_wait state=%0d sig=%b want 0 %b", bus.State, sig, exp); end
        tick();
        checks++;
        if (bus.State !== 3'd0) begin errors++; $display("FAIL lw_fetch_hold state=%0d want 0", bus.State); end
        bus.MemReady = 1'b1;
        tick();
        tick();
        exp = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd2 || sig !== exp) begin errors++; $display("FAIL lw_exec state=%0d sig=%b want 2 %b", bus.State, sig, exp); end
        bus.MemReady = 1'b0;
        tick();
        exp = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.State !== 3'd3 || sig !== exp) begin errors++; $display("FAIL lw_mem_wait%0d state=%0d sig=%b want 3 %b", i, bus.State, sig, exp); end
            tick();
        end
        bus.MemReady = 1'b1;
        #1;
        checks++;
        if (bus.State !== 3'd3 || sig !== exp) begin errors++; $display("FAIL lw_mem_ready state=%0d sig=%b want 3 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000011, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd4 || sig !== exp) begin errors++; $display("FAIL lw_wb state=%0d sig=%b want 4 %b", bus.State, sig, exp); end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd2 || bus.RegWE !== 1'b0) begin
            errors++;
            $display("FAIL lw_done state=%0d count=%0d regwe=%b want 0/2/0", bus.State, bus.InsCount, bus.RegWE);
        end
    endtask

    task automatic test_branch();
        bus.Zero = 1'b1;
        fetch(6'b000100);
        tick();
        exp = {6'b010001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0};
        checks++;
        if (bus.State !== 3'd2 || sig !== exp) begin errors++; $display("FAIL beq_taken state=%0d sig=%b want 2 %b", bus.State, sig, exp); end
        tick();
        bus.Zero = 1'b0;
        fetch(6'b000100);
        tick();
        exp = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0};
        checks++;
        if (bus.State !== 3'd2 || sig !== exp) begin errors++; $display("FAIL beq_not_taken state=%0d sig=%b want 2 %b", bus.State, sig, exp); end
        tick();
        fetch(6'b000101);
        tick();
        exp = {6'b010001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0};
        checks++;
        if (bus.State !== 3'd2 || sig !== exp) begin errors++; $display("FAIL bne_taken state=%0d sig=%b want 2 %b", bus.State, sig, exp); end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd5) begin errors++; $display("FAIL branch_done state=%0d count=%0d want 0/5", bus.State, bus.InsCount); end
    endtask

    task automatic test_jump();
        fetch(6'b000011);
        exp = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd1 || sig !== exp) begin errors++; $display("FAIL jal_decode state=%0d sig=%b want 1 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000011, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd4 || sig !== exp) begin errors++; $display("FAIL jal_wb state=%0d sig=%b want 4 %b", bus.State, sig, exp); end
        tick();
        fetch(6'b000010);
        exp = {6'b010001, 2'b10, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd1 || sig !== exp) begin errors++; $display("FAIL j_decode state=%0d sig=%b want 1 %b", bus.State, sig, exp); end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd7) begin errors++; $display("FAIL j_done state=%0d count=%0d want 0/7", bus.State, bus.InsCount); end
    endtask

    task automatic test_ori_nop();
        fetch(6'b001101);
        exp = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b1};
        checks++;
        if (bus.State !== 3'd1 || sig !== exp) begin errors++; $display("FAIL ori_decode state=%0d sig=%b want 1 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b10, 3'b100, 1'b1};
        checks++;
        if (bus.State !== 3'd2 || sig !== exp) begin errors++; $display("FAIL ori_exec state=%0d sig=%b want 2 %b", bus.State, sig, exp); end
        tick();
        exp = {6'b000011, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd4 || sig !== exp) begin errors++; $display("FAIL ori_wb state=%0d sig=%b want 4 %b", bus.State, sig, exp); end
        tick();
        fetch(6'b111111);
        exp = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd1 || sig !== exp) begin errors++; $display("FAIL nop_decode state=%0d sig=%b want 1 %b", bus.State, sig, exp); end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd9) begin errors++; $display("FAIL nop_done state=%0d count=%0d want 0/9", bus.State, bus.InsCount); end
    endtask

    task automatic test_reset_mid_mem();
        fetch(6'b101011);
        tick();
        bus.MemReady = 1'b0;
        tick();
        exp = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd3 || sig !== exp) begin errors++; $display("FAIL sw_mem state=%0d sig=%b want 3 %b", bus.State, sig, exp); end
        RST = 1'b1;
        #1;
        checks++;
        if (sig !== 18'd0) begin errors++; $display("FAIL rst_gate sig=%b want 0", sig); end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.InsCount !== 16'd0 || bus.MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_mem state=%0d count=%0d memwrite=%b want 0/0/0", bus.State, bus.InsCount, bus.MemWrite);
        end
        RST = 1'b0;
        #1;
        exp = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0};
        checks++;
        if (bus.State !== 3'd0 || sig !== exp) begin errors++; $display("FAIL rst_release state=%0d sig=%b want 0 %b", bus.State, sig, exp); end
    endtask

    task automatic test_wrap();
        force dut.count = 16'hFFFE;
        #1;
        release dut.count;
        #1;
        checks++;
        if (bus.InsCount !== 16'hFFFE) begin errors++; $display("FAIL wrap_preset count=%h want fffe", bus.InsCount); end
        fetch(6'b111111);
        tick();
        checks++;
        if (bus.InsCount !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff count=%h want ffff", bus.InsCount); end
        fetch(6'b111111);
        tick();
        checks++;
        if (bus.InsCount !== 16'h0000 || bus.State !== 3'd0) begin
            errors++;
            $display("FAIL wrap_zero count=%h state=%0d want 0000/0", bus.InsCount, bus.State);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_branch();
        test_jump();
        test_ori_nop();
        test_reset_mid_mem();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
